// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register: dcache-miss stall FSM, bubble injection and flush.
// Optional MEMWB_PERF_EN adds saturating stall_cycles / wb_retired counters.
module mem_wb_latch #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic              mem_RegDst,
  input  logic              mem_JAL,
  input  logic              mem_MemToReg,
  input  logic              mem_dREN,
  input  logic              mem_dWEN,
  input  logic [WORD_W-1:0] mem_Instruction,
  input  logic [WORD_W-1:0] mem_ALUResult,
  input  logic [WORD_W-1:0] mem_PC4,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dload,
  input  logic              flush,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic              wb_RegDst,
  output logic              wb_JAL,
  output logic              wb_MemToReg,
  output logic [WORD_W-1:0] wb_Instruction,
  output logic [WORD_W-1:0] wb_ALUResult,
  output logic [WORD_W-1:0] wb_PC4,
  output logic [WORD_W-1:0] wb_dload
`ifdef MEMWB_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       wb_retired
`endif
);

  typedef enum logic {
    IDLE,
    MEMWAIT
  } state_t;

  state_t state, next_state;
  logic   acc;
  logic   bubble;

  assign acc    = mem_valid & (mem_dREN | mem_dWEN);
  assign bubble = flush | mem_stall | ~mem_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // flush deliberately does not touch the FSM: the dcache access still has to finish
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (acc && !dhit) next_state = MEMWAIT;
      MEMWAIT: if (dhit)         next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_stall = acc & ~dhit;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_valid       <= 1'b0;
      wb_RegWrite    <= 1'b0;
      wb_RegDst      <= 1'b0;
      wb_JAL         <= 1'b0;
      wb_MemToReg    <= 1'b0;
      wb_Instruction <= '0;
      wb_ALUResult   <= '0;
      wb_PC4         <= '0;
      wb_dload       <= '0;
    end else if (bubble) begin
      wb_valid       <= 1'b0;
      wb_RegWrite    <= 1'b0;
      wb_RegDst      <= 1'b0;
      wb_JAL         <= 1'b0;
      wb_MemToReg    <= 1'b0;
      wb_Instruction <= '0;
      wb_ALUResult   <= '0;
      wb_PC4         <= '0;
      wb_dload       <= '0;
    end else begin
      wb_valid       <= 1'b1;
      wb_RegWrite    <= mem_RegWrite;
      wb_RegDst      <= mem_RegDst;
      wb_JAL         <= mem_JAL;
      wb_MemToReg    <= mem_MemToReg;
      wb_Instruction <= mem_Instruction;
      wb_ALUResult   <= mem_ALUResult;
      wb_PC4         <= mem_PC4;
      // dREN together with dWEN is treated as a load
      wb_dload       <= (mem_dREN && dhit) ? dload : '0;
    end
  end

`ifdef MEMWB_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
      wb_retired   <= '0;
    end else begin
      if (mem_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (!bubble && (wb_retired != '1))     wb_retired   <= wb_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_latch.sv
// Randomized self-checking bench for mem_wb_latch with an inline behavioural model.
// Define MEMWB_PERF_EN when compiling to also check the performance counters.
module tb_mem_wb_latch;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        mem_valid, mem_RegWrite, mem_RegDst, mem_JAL, mem_MemToReg;
  logic        mem_dREN, mem_dWEN, dhit, flush;
  logic [31:0] mem_Instruction, mem_ALUResult, mem_PC4, dload;
  logic        mem_stall, wb_valid, wb_RegWrite, wb_RegDst, wb_JAL, wb_MemToReg;
  logic [31:0] wb_Instruction, wb_ALUResult, wb_PC4, wb_dload;
`ifdef MEMWB_PERF_EN
  logic [31:0] stall_cycles, wb_retired;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_wb_latch #(.WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_RegDst(mem_RegDst),
    .mem_JAL(mem_JAL), .mem_MemToReg(mem_MemToReg), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .mem_Instruction(mem_Instruction), .mem_ALUResult(mem_ALUResult), .mem_PC4(mem_PC4),
    .dhit(dhit), .dload(dload), .flush(flush), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_RegDst(wb_RegDst), .wb_JAL(wb_JAL),
    .wb_MemToReg(wb_MemToReg), .wb_Instruction(wb_Instruction), .wb_ALUResult(wb_ALUResult),
    .wb_PC4(wb_PC4), .wb_dload(wb_dload)
`ifdef MEMWB_PERF_EN
    , .stall_cycles(stall_cycles), .wb_retired(wb_retired)
`endif
  );

  // Behavioural model: the WB entry is a record that is either a bubble or a copy of MEM.
  typedef struct {
    bit        valid, regwrite, regdst, jal, memtoreg;
    bit [31:0] instr, alu, pc4, dl;
  } wb_t;

  wb_t         m;
  bit   [31:0] m_stalls, m_retired;

  function automatic bit exp_stall();
    return mem_valid && (mem_dREN || mem_dWEN) && !dhit;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m = '{default: 0};
      m_stalls = 0;
      m_retired = 0;
    end else begin
      bit st;
      st = exp_stall();
      if (flush || st || !mem_valid) begin
        m = '{default: 0};
      end else begin
        m.valid = 1; m.regwrite = mem_RegWrite; m.regdst = mem_RegDst;
        m.jal = mem_JAL; m.memtoreg = mem_MemToReg;
        m.instr = mem_Instruction; m.alu = mem_ALUResult; m.pc4 = mem_PC4;
        m.dl = (mem_dREN && dhit) ? dload : 32'h0;
        if (m_retired != 32'hFFFF_FFFF) m_retired++;
      end
      if (st && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    chk("mem_stall", {31'b0, mem_stall}, {31'b0, exp_stall()});
    chk("wb_valid", {31'b0, wb_valid}, {31'b0, m.valid});
    chk("wb_RegWrite", {31'b0, wb_RegWrite}, {31'b0, m.regwrite});
    chk("wb_RegDst", {31'b0, wb_RegDst}, {31'b0, m.regdst});
    chk("wb_JAL", {31'b0, wb_JAL}, {31'b0, m.jal});
    chk("wb_MemToReg", {31'b0, wb_MemToReg}, {31'b0, m.memtoreg});
    chk("wb_Instruction", wb_Instruction, m.instr);
    chk("wb_ALUResult", wb_ALUResult, m.alu);
    chk("wb_PC4", wb_PC4, m.pc4);
    chk("wb_dload", wb_dload, m.dl);
`ifdef MEMWB_PERF_EN
    chk("stall_cycles", stall_cycles, m_stalls);
    chk("wb_retired", wb_retired, m_retired);
`endif
  end

  task automatic setin(input bit v, rw, rd, jal, m2r, ren, wen,
                       input bit [31:0] instr, alu, pc4, input bit dh, input bit [31:0] dl,
                       input bit fl);
    mem_valid = v; mem_RegWrite = rw; mem_RegDst = rd; mem_JAL = jal; mem_MemToReg = m2r;
    mem_dREN = ren; mem_dWEN = wen; mem_Instruction = instr; mem_ALUResult = alu;
    mem_PC4 = pc4; dhit = dh; dload = dl; flush = fl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  bit hold;

  initial begin
    nRST = 1'b0;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    nRST = 1'b1;

    // Asynchronous reset between edges clears a valid WB entry immediately
    setin(1, 1, 1, 0, 0, 0, 0, 32'h0123_4567, 32'h55, 32'h100, 0, 0, 0);
    tick();
    chk("pre_reset_valid", {31'b0, wb_valid}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("reset_valid", {31'b0, wb_valid}, 32'd0);
    chk("reset_alu", wb_ALUResult, 32'd0);
    chk("reset_instr", wb_Instruction, 32'd0);
    chk("reset_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    nRST = 1'b1;

    // R-type, no access
    setin(1, 1, 1, 0, 0, 0, 0, 32'h0000_0020, 32'h0000_002A, 32'h8, 0, 0, 0);
    #1 chk("rtype_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    chk("rtype_valid", {31'b0, wb_valid}, 32'd1);
    chk("rtype_alu", wb_ALUResult, 32'h2A);
    chk("rtype_regdst", {31'b0, wb_RegDst}, 32'd1);

    // Load miss for 3 cycles, then hit
    setin(1, 1, 0, 0, 1, 1, 0, 32'h8C00_0000, 32'h40, 32'hC, 0, 0, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      #1 chk("miss_stall", {31'b0, mem_stall}, 32'd1);
      tick();
      chk("miss_bubble", {31'b0, wb_valid}, 32'd0);
    end
    dhit = 1'b1; dload = 32'hDEAD_BEEF;
    #1 chk("hit_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    chk("miss_dload", wb_dload, 32'hDEAD_BEEF);
    chk("miss_memtoreg", {31'b0, wb_MemToReg}, 32'd1);
    chk("miss_valid", {31'b0, wb_valid}, 32'd1);

    // Same-cycle load hit
    setin(1, 1, 0, 0, 1, 1, 0, 32'h8C00_0004, 32'h44, 32'h10, 1, 32'h1234_5678, 0);
    #1 chk("hit_nostall", {31'b0, mem_stall}, 32'd0);
    tick();
    chk("hit_dload", wb_dload, 32'h1234_5678);

    // Flush squashes a JAL; repeating without flush lets it through
    setin(1, 1, 0, 1, 0, 0, 0, 32'h0C00_0010, 32'h0, 32'h44, 0, 0, 1);
    tick();
    chk("flush_jal", {31'b0, wb_JAL}, 32'd0);
    chk("flush_valid", {31'b0, wb_valid}, 32'd0);
    flush = 1'b0;
    tick();
    chk("jal_jal", {31'b0, wb_JAL}, 32'd1);
    chk("jal_pc4", wb_PC4, 32'h44);

    // Store miss with flush mid-wait: the stall persists until dhit
    do_reset();
    setin(1, 0, 0, 0, 0, 0, 1, 32'hAC00_0000, 32'h80, 32'h14, 0, 0, 0);
    #1 chk("st_stall0", {31'b0, mem_stall}, 32'd1);
    tick();
    flush = 1'b1;
    #1 chk("st_stall1", {31'b0, mem_stall}, 32'd1);
    tick();
    flush = 1'b0; dhit = 1'b1;
    #1 chk("st_done", {31'b0, mem_stall}, 32'd0);
    tick();
    chk("st_valid", {31'b0, wb_valid}, 32'd1);
    chk("st_dload", wb_dload, 32'd0);
`ifdef MEMWB_PERF_EN
    chk("st_stall_cycles", stall_cycles, 32'd2);
`endif

    // Randomized traffic; MEM inputs held stable while the previous cycle stalled
    hold = 0;
    for (int unsigned c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        #2 nRST = 1'b0;
        tick();
        nRST = 1'b1;
        hold = 0;
      end
      if (hold) begin
        dhit = ($urandom_range(0, 2) == 0);
        dload = $urandom();
        flush = ($urandom_range(0, 7) == 0);
      end else begin
        int unsigned kind;
        kind = $urandom_range(0, 2);
        setin($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, kind == 1, kind == 2,
              $urandom(), $urandom(), $urandom(), $urandom_range(0, 1) == 1, $urandom(),
              $urandom_range(0, 7) == 0);
      end
      hold = exp_stall();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
